// File: rtl/ex_alu_stage.sv
// Execute stage: ID/EX pipeline register, operand forwarding, 64-bit ALU with
// a borrow-chained subtract path, and the EX/MEM result register.
module ex_alu_stage #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [2:0]      id_op,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_wr_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_val,
    output logic            ex_valid,
    output logic [RW-1:0]   ex_rd,
    output logic [XLEN-1:0] ex_result,
    output logic            ex_borrow,
    output logic            ex_zero
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_SLTU = 3'd6,
        OP_SUBB = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        alu_op_e         op;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] a_val;
        logic [XLEN-1:0] b_val;
        logic            use_imm;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    id_ex_t          id_ex;
    logic            borrow_flag;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic            sub_bin;
    logic [XLEN:0]   sub_full;
    logic [XLEN-1:0] result;
    logic            borrow;

    // EX/MEM outranks WB; index 0 is hardwired to zero and never forwarded.
    function automatic logic [XLEN-1:0] forward(
        input logic [RW-1:0]   rs,
        input logic [XLEN-1:0] latched,
        input logic            exv,
        input logic [RW-1:0]   exrd,
        input logic [XLEN-1:0] exres,
        input logic            wbe,
        input logic [RW-1:0]   wbrd,
        input logic [XLEN-1:0] wbv
    );
        if (rs == '0)                   return '0;
        else if (exv && exrd == rs)     return exres;
        else if (wbe && wbrd == rs)     return wbv;
        else                            return latched;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex <= '0;
        end else if (flush) begin
            id_ex.valid <= 1'b0;
        end else if (!stall) begin
            id_ex.valid   <= id_valid;
            id_ex.op      <= alu_op_e'(id_op);
            id_ex.rs1     <= id_rs1;
            id_ex.rs2     <= id_rs2;
            id_ex.rd      <= id_rd;
            id_ex.a_val   <= id_rs1_val;
            id_ex.b_val   <= id_rs2_val;
            id_ex.use_imm <= id_use_imm;
            id_ex.imm     <= id_imm;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        op_a     = forward(id_ex.rs1, id_ex.a_val, ex_valid, ex_rd, ex_result,
                           wb_wr_en, wb_rd, wb_val);
        fwd_b    = forward(id_ex.rs2, id_ex.b_val, ex_valid, ex_rd, ex_result,
                           wb_wr_en, wb_rd, wb_val);
        op_b     = id_ex.use_imm ? id_ex.imm : fwd_b;
        sub_bin  = (id_ex.op == OP_SUBB) ? borrow_flag : 1'b0;
        sub_full = {1'b0, op_a} - {1'b0, op_b} - {{XLEN{1'b0}}, sub_bin};
        result   = '0;
        borrow   = 1'b0;
        unique case (id_ex.op)
            OP_ADD:          result = op_a + op_b;
            OP_SUB, OP_SUBB: begin
                result = sub_full[XLEN-1:0];
                borrow = sub_full[XLEN];
            end
            OP_AND:          result = op_a & op_b;
            OP_OR:           result = op_a | op_b;
            OP_XOR:          result = op_a ^ op_b;
            OP_SLT:          result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: begin
                result = {{(XLEN-1){1'b0}}, sub_full[XLEN]};
                borrow = sub_full[XLEN];
            end
            default:         result = '0;
        endcase
    end

    // Bubbles hold the payload fields; only ex_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_result   <= '0;
            ex_borrow   <= 1'b0;
            ex_zero     <= 1'b0;
            borrow_flag <= 1'b0;
        end else if (stall || !id_ex.valid) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid  <= 1'b1;
            ex_rd     <= id_ex.rd;
            ex_result <= result;
            ex_borrow <= borrow;
            ex_zero   <= (result == '0);
            if (id_ex.op == OP_SUB || id_ex.op == OP_SUBB)
                borrow_flag <= borrow;
        end
    end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios with hand-derived
// constants, then randomized traffic checked against a cycle-level model.
module tb_ex_alu_stage;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [2:0]      id_op;
    logic [RW-1:0]   id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_val, id_rs2_val, id_imm;
    logic            id_use_imm;
    logic            stall, flush;
    logic            wb_wr_en;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_val;
    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            ex_borrow;
    logic            ex_zero;

    int n_tests = 0;
    int n_fail  = 0;

    ex_alu_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .stall(stall), .flush(flush),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_val(wb_val),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_borrow(ex_borrow), .ex_zero(ex_zero)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLT = 3'd5, SLTU = 3'd6, SUBB = 3'd7;

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        bit [2:0]    op;
        bit [RW-1:0] rs1, rs2, rd;
        bit [63:0]   a, b, imm;
        bit          use_imm;
    } m_instr_t;

    m_instr_t  m_pend;          // instruction waiting to execute
    bit        m_ex_valid;
    bit [4:0]  m_ex_rd;
    bit [63:0] m_ex_result;
    bit        m_ex_borrow;
    bit        m_ex_zero;
    bit        m_bflag;

    function automatic bit [63:0] m_src(input bit [4:0] rs, input bit [63:0] latched);
        if (rs == 0) return 64'd0;
        if (m_ex_valid && m_ex_rd == rs) return m_ex_result;
        if (wb_wr_en && wb_rd == rs) return wb_val;
        return latched;
    endfunction

    // Returns {borrow, result} from integer-level definitions of each op.
    function automatic bit [64:0] m_alu(input bit [2:0] op, input bit [63:0] a,
                                        input bit [63:0] b, input bit bin);
        bit [64:0] need;
        need = {1'b0, b} + 65'(bin);
        case (op)
            ADD:     return {1'b0, a + b};
            SUB:     return {a < b, a - b};
            SUBB:    return {{1'b0, a} < need, a - b - 64'(bin)};
            AND_:    return {1'b0, a & b};
            OR_:     return {1'b0, a | b};
            XOR_:    return {1'b0, a ^ b};
            SLT:     return {1'b0, 64'($signed(a) < $signed(b))};
            default: return {a < b, 64'(a < b)};
        endcase
    endfunction

    // Advance one clock: the model consumes the same inputs the DUT sees.
    task automatic tick();
        bit [64:0] r;
        bit [63:0] a, b;
        m_instr_t  n_pend;
        bit        live;
        a = m_src(m_pend.rs1, m_pend.a);
        b = m_pend.use_imm ? m_pend.imm : m_src(m_pend.rs2, m_pend.b);
        r = m_alu(m_pend.op, a, b, m_bflag);
        live = m_pend.valid && !stall;
        n_pend = m_pend;
        if (rst) n_pend = '{default: 0};
        else if (flush) n_pend.valid = 0;
        else if (!stall) begin
            n_pend.valid = id_valid; n_pend.op = id_op;
            n_pend.rs1 = id_rs1; n_pend.rs2 = id_rs2; n_pend.rd = id_rd;
            n_pend.a = id_rs1_val; n_pend.b = id_rs2_val;
            n_pend.imm = id_imm; n_pend.use_imm = id_use_imm;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ex_valid = 0; m_ex_rd = 0; m_ex_result = 0;
            m_ex_borrow = 0; m_ex_zero = 0; m_bflag = 0;
        end else if (!live) begin
            m_ex_valid = 0;
        end else begin
            m_ex_valid = 1; m_ex_rd = m_pend.rd; m_ex_result = r[63:0];
            m_ex_borrow = r[64]; m_ex_zero = (r[63:0] == 0);
            if (m_pend.op == SUB || m_pend.op == SUBB) m_bflag = r[64];
        end
        m_pend = n_pend;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rst = 0; id_valid = 0; id_op = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_imm = 0;
        stall = 0; flush = 0; wb_wr_en = 0; wb_rd = 0; wb_val = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
        id_valid = 1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_val = a; id_rs2_val = b; id_use_imm = 0; id_imm = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        n_tests++;
        if ({ex_valid, ex_rd, ex_result, ex_borrow, ex_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b rd=%0d res=%h b=%b z=%b, want all zero",
                     ex_valid, ex_rd, ex_result, ex_borrow, ex_zero);
        end
    endtask

    task automatic test_sub();
        idle();
        issue(SUB, 5'd1, 5'd2, 5'd10, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444);
        tick();
        idle();
        n_tests++;
        if (ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL sub_latency_early: ex_valid=%b, want 0", ex_valid);
        end
        tick();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_result !== 64'h9999_9999_9999_9999
            || ex_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_basic: v=%b rd=%0d res=%h b=%b, want 1 10 9999999999999999 0",
                     ex_valid, ex_rd, ex_result, ex_borrow);
        end
    endtask

    task automatic test_subb_chain();
        idle();
        issue(SUB, 5'd1, 5'd2, 5'd3, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        issue(SUBB, 5'd4, 5'd5, 5'd7, 64'h0, 64'h0);
        tick();
        idle();
        n_tests++;
        if (ex_result !== 64'h2 || ex_borrow !== 1'b1 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_wrap: v=%b res=%h b=%b, want 1 0000000000000002 1",
                     ex_valid, ex_result, ex_borrow);
        end
        tick();
        n_tests++;
        if (ex_result !== 64'hFFFF_FFFF_FFFF_FFFF || ex_borrow !== 1'b1 || ex_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL subb_chain: rd=%0d res=%h b=%b, want 7 ffffffffffffffff 1",
                     ex_rd, ex_result, ex_borrow);
        end
    endtask

    task automatic test_forward_priority();
        idle();
        issue(ADD, 5'd1, 5'd2, 5'd5, 64'd3, 64'd4);
        tick();
        issue(SUB, 5'd5, 5'd5, 5'd6, 64'd11, 64'd22);
        tick();
        n_tests++;
        if (ex_result !== 64'd7 || ex_rd !== 5'd5) begin
            n_fail++; $display("FAIL fwd_add: rd=%0d res=%0d, want 5 7", ex_rd, ex_result);
        end
        idle();
        wb_wr_en = 1; wb_rd = 5'd5; wb_val = 64'd99;
        tick();
        idle();
        n_tests++;
        if (ex_result !== 64'd0 || ex_zero !== 1'b1 || ex_rd !== 5'd6 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_ex_over_wb: v=%b rd=%0d res=%0d z=%b, want 1 6 0 1",
                     ex_valid, ex_rd, ex_result, ex_zero);
        end
        // WB-only forwarding: EX/MEM now holds x6, WB supplies x9.
        issue(ADD, 5'd9, 5'd2, 5'd12, 64'd1000, 64'd5);
        tick();
        idle();
        wb_wr_en = 1; wb_rd = 5'd9; wb_val = 64'd40;
        tick();
        idle();
        n_tests++;
        if (ex_result !== 64'd45) begin
            n_fail++; $display("FAIL fwd_wb: res=%0d, want 45", ex_result);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        issue(ADD, 5'd1, 5'd2, 5'd8, 64'd1, 64'd1);
        tick();
        idle();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (ex_valid !== 1'b0 || ex_result !== 64'd45) begin
                n_fail++;
                $display("FAIL stall_bubble%0d: v=%b res=%0d, want 0 45 (held)", i, ex_valid, ex_result);
            end
        end
        stall = 0;
        tick();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_result !== 64'd2 || ex_rd !== 5'd8) begin
            n_fail++;
            $display("FAIL stall_release: v=%b rd=%0d res=%0d, want 1 8 2", ex_valid, ex_rd, ex_result);
        end
        issue(ADD, 5'd1, 5'd2, 5'd9, 64'd7, 64'd7);
        tick();
        idle();
        stall = 1; flush = 1;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (ex_valid !== 1'b0 || ex_rd !== 5'd8) begin
                n_fail++;
                $display("FAIL flush_over_stall%0d: v=%b rd=%0d, want 0 8", i, ex_valid, ex_rd);
            end
        end
    endtask

    task automatic test_slt_and_x0();
        idle();
        issue(SLT, 5'd1, 5'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        issue(SLTU, 5'd1, 5'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        tick();
        n_tests++;
        if (ex_result !== 64'd1 || ex_borrow !== 1'b0) begin
            n_fail++; $display("FAIL slt_signed: res=%h b=%b, want 1 0", ex_result, ex_borrow);
        end
        issue(ADD, 5'd1, 5'd2, 5'd0, 64'd5, 64'd6);
        tick();
        n_tests++;
        if (ex_result !== 64'd0 || ex_borrow !== 1'b0 || ex_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu_unsigned: res=%h b=%b z=%b, want 0 0 1", ex_result, ex_borrow, ex_zero);
        end
        issue(ADD, 5'd0, 5'd0, 5'd13, 64'd55, 64'd55);
        tick();
        n_tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd0 || ex_result !== 64'd11) begin
            n_fail++;
            $display("FAIL rd0_valid: v=%b rd=%0d res=%0d, want 1 0 11", ex_valid, ex_rd, ex_result);
        end
        idle();
        tick();
        n_tests++;
        if (ex_result !== 64'd0 || ex_zero !== 1'b1) begin
            n_fail++; $display("FAIL x0_reads_zero: res=%0d z=%b, want 0 1", ex_result, ex_zero);
        end
        id_valid = 1; id_op = ADD; id_rs1 = 5'd0; id_rs1_val = 64'd55;
        id_use_imm = 1; id_imm = 64'd10; id_rs2_val = 64'd500; id_rd = 5'd14;
        tick();
        idle();
        tick();
        n_tests++;
        if (ex_result !== 64'd10) begin
            n_fail++; $display("FAIL use_imm: res=%0d, want 10", ex_result);
        end
    endtask

    task automatic test_rst_midstream();
        idle();
        issue(SUB, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2);
        tick();
        issue(ADD, 5'd1, 5'd2, 5'd4, 64'd8, 64'd8);
        tick();
        issue(XOR_, 5'd1, 5'd2, 5'd5, 64'd8, 64'd9);
        tick();
        issue(OR_, 5'd1, 5'd2, 5'd6, 64'd3, 64'd4);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({ex_valid, ex_rd, ex_result, ex_borrow, ex_zero} !== '0) begin
                n_fail++;
                $display("FAIL rst_midstream%0d: v=%b rd=%0d res=%h b=%b z=%b, want all zero",
                         i, ex_valid, ex_rd, ex_result, ex_borrow, ex_zero);
            end
        end
        idle();
        tick();
        n_tests++;
        if (ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_flushed_idex: v=%b, want 0", ex_valid);
        end
        issue(SUBB, 5'd1, 5'd2, 5'd7, 64'd5, 64'd3);
        tick();
        idle();
        tick();
        n_tests++;
        if (ex_result !== 64'd2 || ex_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL subb_after_rst: res=%0d b=%b, want 2 0", ex_result, ex_borrow);
        end
    endtask

    function automatic logic [63:0] rval();
        case ($urandom_range(3, 0))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        int errs = 0;
        idle();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(59, 0) == 0);
            id_valid   = ($urandom_range(3, 0) != 0);
            id_op      = 3'($urandom_range(7, 0));
            id_rs1     = 5'($urandom_range(5, 0));
            id_rs2     = 5'($urandom_range(5, 0));
            id_rd      = 5'($urandom_range(5, 0));
            id_rs1_val = rval();
            id_rs2_val = rval();
            id_imm     = rval();
            id_use_imm = ($urandom_range(3, 0) == 0);
            stall      = ($urandom_range(5, 0) == 0);
            flush      = ($urandom_range(9, 0) == 0);
            wb_wr_en   = ($urandom_range(1, 0) == 1);
            wb_rd      = 5'($urandom_range(5, 0));
            wb_val     = rval();
            tick();
            n_tests++;
            if ({ex_valid, ex_rd, ex_result, ex_borrow, ex_zero} !==
                {m_ex_valid, m_ex_rd, m_ex_result, m_ex_borrow, m_ex_zero}) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got v=%b rd=%0d res=%h b=%b z=%b, want v=%b rd=%0d res=%h b=%b z=%b",
                             i, ex_valid, ex_rd, ex_result, ex_borrow, ex_zero,
                             m_ex_valid, m_ex_rd, m_ex_result, m_ex_borrow, m_ex_zero);
            end
        end
        idle();
    endtask

    initial begin
        m_pend = '{default: 0};
        m_ex_valid = 0; m_ex_rd = 0; m_ex_result = 0;
        m_ex_borrow = 0; m_ex_zero = 0; m_bflag = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_sub();
        test_subb_chain();
        test_forward_priority();
        test_stall_flush();
        test_slt_and_x0();
        test_rst_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
